// File: rtl/sobel_result_writer.sv
// Buffers Sobel result lines in a FIFO and issues CCI-P channel-1 writes.
// Define SOBEL_WR_PERF_EN to add the stall_cycles/fifo_hwm counters.
module sobel_result_writer #(
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_W     = 42,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_lines,
  input  logic [511:0]      data_in,
  input  logic              valid_in,
  input  logic              c1_almfull,
  input  logic              c1_rsp_valid,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [511:0]      wr_data,
  output logic [15:0]       wr_mdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  lines_acked
`ifdef SOBEL_WR_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [$clog2(FIFO_DEPTH):0] fifo_hwm
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [511:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [PW:0]       r_count, w_count_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_num, r_accepted, r_issued;
  logic [CNT_W-1:0]  r_written, r_acked;
  logic              r_overflow;
  logic              r_wr_valid;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [511:0]      r_wr_data;
  logic [15:0]       r_wr_mdata;

  logic w_start_ok, w_run, w_busy, w_empty, w_full;
  logic w_want, w_push, w_drop, w_pop, w_skip;

  assign w_start_ok = start &&
                      (r_state == S_IDLE || r_state == S_DONE);
  assign w_run   = (r_state == S_RUN);
  assign w_busy  = w_run || (r_state == S_DRAIN);
  assign w_empty = (r_count == '0);
  assign w_pop   = w_run && !w_empty && !c1_almfull &&
                   (r_issued < r_num);
  // A same-cycle pop frees the slot the push needs.
  assign w_full  = (r_count == DEPTH_C) && !w_pop;
  assign w_want  = w_run && valid_in && (r_accepted < r_num);
  assign w_push  = w_want && !w_full;
  assign w_drop  = w_want && w_full;
  assign w_skip  = w_run && (r_accepted == r_num) && w_empty &&
                   (r_issued < r_num);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + (PW+1)'(1);
    else if (!w_push && w_pop)
      w_count_nxt = r_count - (PW+1)'(1);
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE:
        if (start)
          w_state_nxt = (num_lines == '0) ? S_DONE : S_RUN;
      S_RUN:
        if (r_issued == r_num) w_state_nxt = S_DRAIN;
      S_DRAIN:
        if (r_acked == r_written) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_base     <= '0;
      r_num      <= '0;
      r_accepted <= '0;
      r_issued   <= '0;
      r_written  <= '0;
      r_acked    <= '0;
      r_overflow <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_mdata <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_valid <= w_pop;
      if (w_pop) begin
        r_wr_addr  <= r_base + ADDR_W'(r_issued);
        r_wr_data  <= r_mem[r_rptr];
        r_wr_mdata <= r_issued[15:0];
      end
      if (w_start_ok) begin
        r_base     <= base_addr;
        r_num      <= num_lines;
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_count    <= '0;
        r_accepted <= '0;
        r_issued   <= '0;
        r_written  <= '0;
        r_acked    <= '0;
        r_overflow <= 1'b0;
      end else begin
        r_count <= w_count_nxt;
        if (w_push) r_wptr <= r_wptr + PW'(1);
        if (w_want) r_accepted <= r_accepted + CNT_W'(1);
        if (w_drop) r_overflow <= 1'b1;
        if (w_pop) begin
          r_rptr    <= r_rptr + PW'(1);
          r_issued  <= r_issued + CNT_W'(1);
          r_written <= r_written + CNT_W'(1);
        end
        // Addresses of dropped beats are never written.
        if (w_skip) r_issued <= r_num;
        if (w_busy && c1_rsp_valid)
          r_acked <= r_acked + CNT_W'(1);
      end
    end
  end

  assign wr_valid    = r_wr_valid;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign wr_mdata    = r_wr_mdata;
  assign busy        = w_busy;
  assign done        = (r_state == S_DONE);
  assign overflow    = r_overflow;
  assign lines_acked = r_acked;

`ifdef SOBEL_WR_PERF_EN
  logic [CNT_W-1:0] r_stall;
  logic [PW:0]      r_hwm;

  always_ff @(posedge clk) begin
    if (reset || w_start_ok) begin
      r_stall <= '0;
      r_hwm   <= '0;
    end else begin
      if (w_run && !w_empty && c1_almfull)
        r_stall <= r_stall + CNT_W'(1);
      if (w_count_nxt > r_hwm) r_hwm <= w_count_nxt;
    end
  end

  assign stall_cycles = r_stall;
  assign fifo_hwm     = r_hwm;
`endif

endmodule

// File: doc/sobel_result_writer.md
Name: sobel_result_writer

Overview:
- Downstream stage of the Sobel filter core: consumes 512-bit result cache lines from the filter's data_out/valid_out stream.
- The filter stream has no backpressure, so results are buffered in an internal FIFO.
- Issues CCI-P channel-1 write requests to a contiguous output buffer, throttled by c1TxAlmFull.
- Counts write responses; reports completion to the requestor/CSR logic.

Parameters:
- FIFO_DEPTH, 64, result FIFO entries (512-bit each); power of 2, >= 4.
- ADDR_W, 42, cache-line address width (CCI-P CL address).
- CNT_W, 32, width of line counters and num_lines.

Ports:
- clk  in  1  CCI-P clock (pClk domain).
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a job; honoured only in IDLE or DONE.
- base_addr  in  ADDR_W  output buffer base CL address; latched on start.
- num_lines  in  CNT_W  lines to write; latched on start.
- data_in  in  512  result line from the filter.
- valid_in  in  1  data_in qualifier; no backpressure.
- c1_almfull  in  1  c1TxAlmFull from the MPF side.
- c1_rsp_valid  in  1  one write response (single-CL) received on c1Rx.
- wr_valid  out  1  write request valid, one cycle per request.
- wr_addr  out  ADDR_W  request CL address.
- wr_data  out  512  request payload.
- wr_mdata  out  16  request mdata = line index [15:0].
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- overflow  out  1  sticky: a beat was dropped because the FIFO was full.
- lines_acked  out  CNT_W  write responses counted in the current job.

Behaviour:
- Reset: state IDLE; FIFO empty; all counters 0; wr_valid, wr_addr, wr_data, wr_mdata, busy, done, overflow, lines_acked all 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start:
  - Latch base_addr and num_lines.
  - Clear accepted, issued and acked counters, overflow and FIFO.
  - If num_lines == 0, go to DONE; otherwise go to RUN.
- start in RUN or DRAIN is ignored.
- Accept (RUN only):
  - A beat with valid_in = 1 is pushed when accepted < num_lines and the FIFO is not full; accepted increments.
  - If accepted < num_lines and the FIFO is full, the beat is dropped, overflow is set, and accepted still increments so the job terminates.
  - Beats after accepted == num_lines, and beats in IDLE/DRAIN/DONE, are discarded silently.
- Issue (RUN):
  - Issue when the FIFO is non-empty, c1_almfull == 0 (sampled in the same cycle) and issued < num_lines.
  - Pop the head. Next cycle: wr_valid = 1, wr_addr = base + issued (mod 2^ADDR_W), wr_data = head, wr_mdata = issued[15:0].
  - issued increments; at most one request per cycle.
- Dropped beats produce no write. After accepted == num_lines and the FIFO is empty, issued is forced to num_lines (remaining addresses are skipped).
- Latency: a beat with valid_in at cycle N and an empty FIFO with almfull low gives wr_valid at N+2.
- Transition RUN -> DRAIN when issued == num_lines.
- lines_acked increments on each c1_rsp_valid while busy; responses outside busy are ignored.
- DRAIN -> DONE when lines_acked == number of actually issued writes.
- done stays high until the next start or reset.
- Simultaneous push and pop on the same cycle are both honoured; full and empty are computed from pre-cycle occupancy plus the pop.
- c1_almfull high holds the FIFO head. FIFO occupancy is unaffected except by pushes.
- Reset mid-job aborts immediately to the reset state. Outstanding responses arriving afterwards are ignored.

Optional Feature:
- Macro SOBEL_WR_PERF_EN.
- When defined: adds output ports stall_cycles (CNT_W) and fifo_hwm ($clog2(FIFO_DEPTH)+1).
  - stall_cycles counts RUN cycles with FIFO non-empty and c1_almfull = 1.
  - fifo_hwm holds peak occupancy.
  - Both clear on an honoured start and on reset.
- When undefined: the ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Basic: base = 0x1000, num_lines = 4, four beats D0..D3 on consecutive cycles, almfull = 0 -> 4 writes at 0x1000..0x1003, mdata 0..3, first wr_valid 2 cycles after D0. After 4 responses -> done = 1, lines_acked = 4.
- Backpressure: num_lines = 8, almfull held high for 20 cycles while 8 beats arrive -> no wr_valid during the hold; after release, 8 consecutive writes in order; overflow = 0.
- Overflow: FIFO_DEPTH = 4, num_lines = 10, almfull high, 10 beats -> overflow = 1; 4 writes (0x0..0x3) after release; job reaches DONE after 4 responses.
- Zero length: start with num_lines = 0 -> done = 1 the next cycle; no wr_valid.
- Mid-job reset: reset asserted after 2 of 6 writes -> all outputs 0 next cycle. A new start with num_lines = 2 writes exactly 2 lines at the new base.
- Restart and extras: start pulse during RUN is ignored. Extra beats beyond num_lines produce no writes. A start from DONE clears done and lines_acked.
